// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//
// Bit-serial-by-nibble adder. One 4-bit ripple slice is reused once per nibble, LSB first,
// to compute {carry_o, sum_o} = a_i + b_i + cin_i. Operands are latched when start_i is
// accepted in idle, so later input changes have no effect on the operation in flight.
//
// Ports:
//   clk_i    sole clock, rising edge
//   rst_i    synchronous active-high reset
//   start_i  begin an addition (sampled only when idle)
//   a_i      operand A, W = 4*NIBBLES bits
//   b_i      operand B
//   cin_i    carry-in
//   sum_o    registered result (valid while done_o is high)
//   carry_o  registered carry-out of the top nibble
//   busy_o   high while adding or signalling done
//   done_o   one-cycle pulse, sum_o/carry_o valid
module nibble_serial_adder_ctrl #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W      = 4 * NIBBLES,
  localparam int unsigned IdxW   = $clog2(NIBBLES)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             cy_q, cy_d;       // running carry between nibbles
  logic             carry_q, carry_d; // carry output, loaded only on the last nibble

  logic [3:0]       a_nib, b_nib;
  logic [4:0]       slice;

  // Shared slice: select the current nibble of each latched operand.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned n = 0; n < NIBBLES; n++) begin
      if (idx_q == IdxW'(n)) begin
        a_nib = a_q[4*n +: 4];
        b_nib = b_q[4*n +: 4];
      end
    end
    slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, cy_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    carry_d = carry_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          cy_d    = cin_i;
          idx_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        for (int unsigned n = 0; n < NIBBLES; n++) begin
          if (idx_q == IdxW'(n)) begin
            sum_d[4*n +: 4] = slice[3:0];
          end
        end
        cy_d = slice[4];
        if (idx_q == LastIdx) begin
          // Index parks at the last nibble; the next start reloads it.
          carry_d = slice[4];
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
    end
  end

  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign busy_o  = (state_q != StIdle);
  assign done_o  = (state_q == StDone);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl (NIBBLES = 4, W = 16).
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;
  localparam int unsigned Lat     = NIBBLES + 1; // edges from acceptance edge to done visible

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic [W-1:0] sum;
  logic         carry, busy, done;

  int errors = 0;
  int checks = 0;

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .cin_i   (cin),
    .sum_o   (sum),
    .carry_o (carry),
    .busy_o  (busy),
    .done_o  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One operation: start pulse, wait for done (bounded), check latency and pulse shape.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input bit scramble, output logic [W-1:0] rs, output logic rc);
    int lat;
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    if (scramble) begin
      a = '1; b = '1; cin = 1'b1;
    end
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, Lat);
    check("busy_with_done", {31'b0, busy}, 32'd1);
    rs = sum;
    rc = carry;
    @(posedge clk); #1;
    check("done_single_cycle", {31'b0, done}, 32'd0);
    check("busy_low_after_done", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    logic [W:0]   ref_v;
    int           n_done, n_idle, first_done;
    vecs[0] = '{a: 16'h0003, b: 16'h0001, cin: 1'b0, s: 16'h0004, c: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, s: 16'h0000, c: 1'b1};
    vecs[2] = '{a: 16'h1234, b: 16'h5678, cin: 1'b0, s: 16'h68AC, c: 1'b0};
    vecs[3] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, s: 16'h0000, c: 1'b1};
    vecs[4] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, s: 16'hFFFF, c: 1'b1};
    vecs[5] = '{a: 16'h0F0F, b: 16'h00F1, cin: 1'b0, s: 16'h1000, c: 1'b0};
    vecs[6] = '{a: 16'h0000, b: 16'h0000, cin: 1'b0, s: 16'h0000, c: 1'b0};
    vecs[7] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, s: 16'h8000, c: 1'b0};
    vecs[8] = '{a: 16'hABCD, b: 16'h1111, cin: 1'b1, s: 16'hBCDF, c: 1'b0};
    vecs[9] = '{a: 16'h9999, b: 16'h7777, cin: 1'b1, s: 16'h1111, c: 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", {16'b0, sum}, 32'h0);
    check("rst_carry", {31'b0, carry}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table; vector 2 also scrambles inputs after acceptance.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, (i == 2), rs, rc);
      check($sformatf("vec%0d_sum", i), {16'b0, rs}, {16'b0, vecs[i].s});
      check($sformatf("vec%0d_carry", i), {31'b0, rc}, {31'b0, vecs[i].c});
    end

    // Idle with start low: result holds (last vector 0x1111, carry 1).
    repeat (3) @(posedge clk);
    #1;
    check("hold_sum", {16'b0, sum}, 32'h1111);
    check("hold_carry", {31'b0, carry}, 32'h1);
    check("hold_busy", {31'b0, busy}, 32'h0);

    // Reset mid-ADD: partial sum cleared, no done pulse.
    @(negedge clk);
    a = 16'h9999; b = 16'h7777; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_sum", {16'b0, sum}, 32'h0);
    check("midrst_carry", {31'b0, carry}, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, rs, rc);
    check("after_rst_sum", {16'b0, rs}, 32'h0);
    check("after_rst_carry", {31'b0, rc}, 32'h1);

    // Start held high through reset and beyond: start ignored under reset and while busy.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ignored", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0; n_idle = 0; first_done = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (!busy) n_idle++;
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = k;
        check($sformatf("held_sum_k%0d", k), {16'b0, sum}, 32'h3333);
      end
    end
    check("held_first_done", first_done, 5);
    check("held_done_count", n_done, 5);
    check("held_idle_count", n_idle, 5);
    @(negedge clk);
    start = 1'b0;

    // Random operations against a+b+cin.
    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0] ra, rb;
      logic         rcin;
      ra = W'($urandom);
      rb = W'($urandom);
      rcin = 1'($urandom);
      ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
      run_op(ra, rb, rcin, 1'b0, rs, rc);
      check($sformatf("rand%0d_a%0h_b%0h_c%0d", k, ra, rb, rcin),
            {15'b0, rc, rs}, {15'b0, ref_v});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
